// File: rtl/flop_fifo_if.sv
// Handshake bundle between a flop_fifo and its producer/consumer.
// Carries the err flag only when FIFO_ERR_FLAG_EN is defined.
interface flop_fifo_if #(
    parameter int unsigned bits = 16
);
    logic [bits-1:0] Din;
    logic [bits-1:0] Dout;
    logic            push;
    logic            pop;
    logic            full;
    logic            pndng;
`ifdef FIFO_ERR_FLAG_EN
    logic            err;
`endif

    modport master (
`ifdef FIFO_ERR_FLAG_EN
        input  err,
`endif
        output Din, push, pop,
        input  Dout, full, pndng
    );

    modport slave (
`ifdef FIFO_ERR_FLAG_EN
        output err,
`endif
        input  Din, push, pop,
        output Dout, full, pndng
    );
endinterface

// File: rtl/flop_fifo.sv
// First-word-fall-through FIFO in flip-flops, any depth >= 2.
// Define FIFO_ERR_FLAG_EN to add a sticky overflow/underflow flag (err).
module flop_fifo #(
    parameter int unsigned depth = 8,
    parameter int unsigned bits  = 16
) (
    input  logic         clk,
    input  logic         rst,
    flop_fifo_if.slave   fifo_io
);
    localparam int unsigned PtrW = $clog2(depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [bits-1:0] mem_q [depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full, pndng;
    logic            do_push, do_pop;

    assign full  = (count_q == CntW'(depth));
    assign pndng = (count_q != '0);

    // A pop in the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_push = fifo_io.push && (!full || fifo_io.pop);
    assign do_pop  = fifo_io.pop && pndng;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= fifo_io.Din;
        end
    end

    assign fifo_io.Dout  = pndng ? mem_q[rd_ptr_q] : '0;
    assign fifo_io.full  = full;
    assign fifo_io.pndng = pndng;

`ifdef FIFO_ERR_FLAG_EN
    logic err_q, err_d;

    // A pop paired with a push on an empty FIFO is not an underflow.
    always_comb begin
        err_d = err_q;
        if (fifo_io.push && !fifo_io.pop && full) begin
            err_d = 1'b1;
        end
        if (fifo_io.pop && !fifo_io.push && !pndng) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign fifo_io.err = err_q;
`endif
endmodule

// File: tb/tb_flop_fifo.sv
// Directed self-checking bench for flop_fifo (depth 8, 16-bit words).
// Checks err as well when FIFO_ERR_FLAG_EN is defined.
module tb_flop_fifo;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    flop_fifo_if #(.bits(16)) fifo_if ();

    flop_fifo #(
        .depth(8),
        .bits (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .fifo_io(fifo_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge with the given request, sampled 1 time unit later.
    task automatic step(input logic push, input logic pop, input logic [15:0] din);
        fifo_if.push = push;
        fifo_if.pop  = pop;
        fifo_if.Din  = din;
        @(posedge clk);
        #1;
        fifo_if.push = 1'b0;
        fifo_if.pop  = 1'b0;
    endtask

    task automatic status(input string tag, input logic full, input logic pndng,
                          input logic [15:0] dout);
        check({tag, ".full"},  32'(fifo_if.full),  32'(full));
        check({tag, ".pndng"}, 32'(fifo_if.pndng), 32'(pndng));
        check({tag, ".Dout"},  32'(fifo_if.Dout),  32'(dout));
    endtask

    task automatic check_err(input string tag, input logic exp);
`ifdef FIFO_ERR_FLAG_EN
        check({tag, ".err"}, 32'(fifo_if.err), 32'(exp));
`else
        if (exp === 1'bx) $display("%s", tag);
`endif
    endtask

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        rst          = 1'b1;
        fifo_if.push = 1'b0;
        fifo_if.pop  = 1'b0;
        fifo_if.Din  = '0;
        repeat (2) @(posedge clk);
        #1;
        status("por", 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;

        // Asynchronous reset with three words stored
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 16'(i));
        status("pre_rst", 1'b0, 1'b1, 16'h0001);
        #2 rst = 1'b1;
        #1;
        status("async_rst", 1'b0, 1'b0, 16'h0000);
        check_err("async_rst", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 16'h0000);
        status("pop_after_rst", 1'b0, 1'b0, 16'h0000);

        // Push with pop on an empty FIFO: only the push takes effect
        rst = 1'b1;
        #1 rst = 1'b0;
        step(1'b1, 1'b1, 16'h00FF);
        status("pp_empty", 1'b0, 1'b1, 16'h00FF);
        check_err("pp_empty", 1'b0);
        step(1'b0, 1'b1, 16'h0000);
        status("pp_empty_drain", 1'b0, 1'b0, 16'h0000);

        // Single word round trip
        step(1'b1, 1'b0, 16'hA5A5);
        status("single", 1'b0, 1'b1, 16'hA5A5);
        step(1'b0, 1'b1, 16'h0000);
        status("single_pop", 1'b0, 1'b0, 16'h0000);

        // Fill, overflow, ordered drain
        for (int i = 1; i <= 8; i++) begin
            check("fill.full_before", 32'(fifo_if.full), 32'd0);
            step(1'b1, 1'b0, 16'(i));
        end
        status("filled", 1'b1, 1'b1, 16'h0001);
        check_err("filled", 1'b0);
        step(1'b1, 1'b0, 16'h0009);
        status("overflow", 1'b1, 1'b1, 16'h0001);
        check_err("overflow", 1'b1);
        for (int i = 1; i <= 8; i++) begin
            check("drain.Dout", 32'(fifo_if.Dout), 32'(i));
            step(1'b0, 1'b1, 16'h0000);
        end
        status("drained", 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0000);
        status("underflow", 1'b0, 1'b0, 16'h0000);
        check_err("underflow_sticky", 1'b1);

        // Wrap-around across the pointer boundary
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0050 + 16'(i));
        for (int i = 0; i < 5; i++) begin
            check("wrap5.Dout", 32'(fifo_if.Dout), 32'h0050 + 32'(i));
            step(1'b0, 1'b1, 16'h0000);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i));
        status("wrap6", 1'b0, 1'b1, 16'h0100);
        for (int i = 0; i < 6; i++) begin
            check("wrap6.Dout", 32'(fifo_if.Dout), 32'h0100 + 32'(i));
            step(1'b0, 1'b1, 16'h0000);
        end
        status("wrap_empty", 1'b0, 1'b0, 16'h0000);

        // Push with pop while full
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(i));
        step(1'b1, 1'b1, 16'h0009);
        status("pp_full", 1'b1, 1'b1, 16'h0002);
        for (int i = 2; i <= 9; i++) begin
            check("pp_full.Dout", 32'(fifo_if.Dout), 32'(i));
            step(1'b0, 1'b1, 16'h0000);
        end
        status("pp_full_empty", 1'b0, 1'b0, 16'h0000);

        // Reset clears the sticky flag
        rst = 1'b1;
        #1;
        check_err("rst_clears", 1'b0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
